morse_key_decoder: RTL
======================

// Module: morse_key_decoder
// PURPOSE
//  Upstream of the seven-segment display stage. Debounces a raw Morse key and
//  times presses as dot/dash. Detects the inter-letter gap and outputs the
//  decoded ASCII letter on ascii_char with a letter_done strobe. The display
//  uses the rising edge of letter_done to advance digits, so letter_done must
//  be glitch-free and registered.
// PARAMETERS
//  DEBOUNCE_CYC   1_000_000  cycles key_sync must be stable before key_db follows
//  DOT_MAX_CYC    20_000_000 press < this is a dot; press >= this is a dash
//  LETTER_GAP_CYC 60_000_000 release idle cycles that end a letter
//  DONE_HOLD_CYC  1000       cycles letter_done is held high (>=2)
// PORTS
//  clock       in   1  system clock
//  reset       in   1  asynchronous, active-high
//  key_in      in   1  raw key, asynchronous, active-high
//  ascii_char  out  8  last decoded character; held until the next letter
//  letter_done out  1  high for DONE_HOLD_CYC cycles per decoded letter
//  sym_count   out  3  symbols collected for the current letter (0..6, saturating)
//  busy        out  1  high in PRESS, GAP or EMIT
// BEHAVIOUR
//  - Reset (async): ascii_char=8'h20, letter_done=0, sym_count=0, busy=0,
//    state=IDLE, key_db=0, all counters=0, code=0.
//  - key_in goes through a 2-flop synchroniser to key_sync. key_db toggles
//    after key_sync differs from key_db for DEBOUNCE_CYC consecutive cycles.
//    A shorter pulse is discarded.
//  - Counters are $clog2(param+1) wide. press_cnt saturates at DOT_MAX_CYC.
//  - FSM states:
//    IDLE:  if key_db==1, go to PRESS and set press_cnt=0.
//    PRESS: increment press_cnt. When key_db falls, append a symbol:
//           dot if press_cnt<DOT_MAX_CYC, else dash. Then go to GAP and set gap_cnt=0.
//    GAP:   if key_db rises, go to PRESS (the letter continues).
//           If gap_cnt==LETTER_GAP_CYC-1, go to EMIT. Otherwise increment gap_cnt.
//    EMIT:  cycle 1: ascii_char <= lookup(sym_count, code).
//           cycle 2: letter_done <= 1, held DONE_HOLD_CYC cycles, then cleared.
//           Then clear code and sym_count and go to IDLE.
//  - ascii_char is stable at least 1 cycle before and all cycles after the
//    rising edge of letter_done.
//  - Symbol store: code[4:0] shifts left, LSB gets the new symbol (1=dash).
//    sym_count increments and saturates at 6. A value of 6 means overflow.
//  - Lookup is the ITU letter table A-Z for 1-4 symbols, giving uppercase ASCII.
//    An unassigned pattern, 5 symbols without the macro, or sym_count==6
//    returns 8'h2D ('-').
//  - If a key press happens during EMIT, it is not timed until IDLE. IDLE then
//    enters PRESS on the key_db level, so the measured press is shortened.
//  - If key_db rises and gap_cnt hits its terminal value in the same cycle,
//    the press wins: stay in the letter and go to PRESS.
//  - Reset mid-PRESS, GAP or EMIT aborts. No letter_done is produced.
// CONFIGURATION
//  MORSE_DIGITS_EN defined:
//    5-symbol ITU digit codes decode to '0'-'9' (8'h30-8'h39).
//  MORSE_DIGITS_EN undefined:
//    every 5-symbol pattern gives '-' (8'h2D). The digit table is not synthesised.
// TESTING (DEBOUNCE_CYC=4, DOT_MAX_CYC=20, LETTER_GAP_CYC=60, DONE_HOLD_CYC=8)
//  1. Press 10 cycles, then release.
//     -> Letter ends 60 cycles after the debounced fall. ascii_char=8'h45 ('E'),
//        then letter_done high 8 cycles. sym_count=1 before the clear.
//  2. Press 10, gap 30, press 30, release.
//     -> ascii_char=8'h41 ('A'). Exactly one letter_done pulse.
//     Press of exactly 20 cycles -> counts as a dash ('T' = 8'h54).
//  3. Six dots with 30-cycle gaps -> 8'h2D.
//     Three dashes -> 8'h4F ('O').
//  4. key_in high for 2 cycles, plus chatter (1-cycle toggles) inside a
//     10-cycle press.
//     -> Glitch-only stimulus: no state change, no letter_done.
//     -> Chattered press: decodes as a single 'E'.
//  5. Five dashes.
//     -> 8'h30 ('0') with MORSE_DIGITS_EN, 8'h2D without it.
//  6. Assert reset 5 cycles into GAP after one dot.
//     -> All outputs at reset values, and no letter_done. Then a dash -> 'T' 8'h54.

Source files
------------

// File: rtl/morse_key_decoder_if.sv
// Bundles the Morse key input with the decoded-character outputs of the decoder.
// Latency: none; this only groups wires.
// Backpressure: none; letter_done is a timed strobe, and consumers edge-detect it.
//
// Ports (signals carried):
//   key_in      raw key, asynchronous, active-high (consumer side drives it)
//   ascii_char  last decoded character, held until the next letter
//   letter_done strobe held high for a fixed number of cycles per decoded letter
//   sym_count   symbols collected for the current letter (0..6, 6 = overflow)
//   busy        decoder is timing a press, waiting out a gap, or emitting
// The master modport is the decoder side. The slave modport is the key/display side.
interface morse_key_decoder_if;
    logic       key_in;
    logic [7:0] ascii_char;
    logic       letter_done;
    logic [2:0] sym_count;
    logic       busy;

    modport master (
        input  key_in,
        output ascii_char,
        output letter_done,
        output sym_count,
        output busy
    );

    modport slave (
        output key_in,
        input  ascii_char,
        input  letter_done,
        input  sym_count,
        input  busy
    );
endinterface

// File: rtl/morse_key_decoder.sv
// Debounces a raw Morse key, times each press as a dot or dash, and emits the decoded ASCII letter.
// Latency: about 2+DEBOUNCE_CYC cycles key-to-key_db, then LETTER_GAP_CYC idle cycles end a letter.
// Backpressure: none; letter_done is a registered strobe held DONE_HOLD_CYC cycles.
//
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high; aborts any letter in progress
//   bus    morse_key_decoder_if.master carrying key_in, ascii_char, letter_done,
//          sym_count and busy
// Optional feature macro: MORSE_DIGITS_EN. When defined, 5-symbol digit codes decode to '0'..'9'.
// When it is undefined, every 5-symbol pattern decodes to '-'.
module morse_key_decoder #(
    parameter int unsigned DEBOUNCE_CYC   = 1_000_000,
    parameter int unsigned DOT_MAX_CYC    = 20_000_000,
    parameter int unsigned LETTER_GAP_CYC = 60_000_000,
    parameter int unsigned DONE_HOLD_CYC  = 1000
) (
    input  logic                clock,
    input  logic                reset,
    morse_key_decoder_if.master bus
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int PW = $clog2(DOT_MAX_CYC + 1);
    localparam int GW = $clog2(LETTER_GAP_CYC + 1);
    // The emit counter also needs one extra step: the cycle that loads ascii_char
    // comes before the letter_done window.
    localparam int HW = $clog2(DONE_HOLD_CYC + 2);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [PW-1:0] DOT_MAX  = PW'(DOT_MAX_CYC);
    localparam logic [GW-1:0] GAP_LAST = GW'(LETTER_GAP_CYC - 1);
    localparam logic [HW-1:0] HOLD_END = HW'(DONE_HOLD_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          sync1_q,       sync1_d;
    logic          key_sync_q,    key_sync_d;
    logic          key_db_q,      key_db_d;
    logic [DW-1:0] db_cnt_q,      db_cnt_d;
    state_t        state_q,       state_d;
    logic [PW-1:0] press_cnt_q,   press_cnt_d;
    logic [GW-1:0] gap_cnt_q,     gap_cnt_d;
    logic [HW-1:0] hold_cnt_q,    hold_cnt_d;
    logic [4:0]    code_q,        code_d;
    logic [2:0]    sym_count_q,   sym_count_d;
    logic [7:0]    ascii_char_q,  ascii_char_d;
    logic          letter_done_q, letter_done_d;

    logic [PW-1:0] press_inc;

    // ------------------------------------------------------------------
    // Symbol-pattern lookup. The code LSB holds the most recent symbol (1 = dash).
    // Bits above the symbol count are always zero, but they are wildcarded anyway.
    // ------------------------------------------------------------------
    function automatic logic [7:0] decode(input logic [2:0] n, input logic [4:0] c);
        logic [7:0] ch;
        ch = 8'h2D;
        casez ({n, c})
            8'b001_????0: ch = "E";
            8'b001_????1: ch = "T";
            8'b010_???00: ch = "I";
            8'b010_???01: ch = "A";
            8'b010_???10: ch = "N";
            8'b010_???11: ch = "M";
            8'b011_??000: ch = "S";
            8'b011_??001: ch = "U";
            8'b011_??010: ch = "R";
            8'b011_??011: ch = "W";
            8'b011_??100: ch = "D";
            8'b011_??101: ch = "K";
            8'b011_??110: ch = "G";
            8'b011_??111: ch = "O";
            8'b100_?0000: ch = "H";
            8'b100_?0001: ch = "V";
            8'b100_?0010: ch = "F";
            8'b100_?0100: ch = "L";
            8'b100_?0110: ch = "P";
            8'b100_?0111: ch = "J";
            8'b100_?1000: ch = "B";
            8'b100_?1001: ch = "X";
            8'b100_?1010: ch = "C";
            8'b100_?1011: ch = "Y";
            8'b100_?1100: ch = "Z";
            8'b100_?1101: ch = "Q";
`ifdef MORSE_DIGITS_EN
            8'b101_01111: ch = "1";
            8'b101_00111: ch = "2";
            8'b101_00011: ch = "3";
            8'b101_00001: ch = "4";
            8'b101_00000: ch = "5";
            8'b101_10000: ch = "6";
            8'b101_11000: ch = "7";
            8'b101_11100: ch = "8";
            8'b101_11110: ch = "9";
            8'b101_11111: ch = "0";
`endif
            default:      ch = 8'h2D;
        endcase
        return ch;
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser and debounce. key_db flips only after key_sync has disagreed
    // with it for DEBOUNCE_CYC consecutive cycles. Any agreement restarts the count,
    // so shorter pulses and chatter are discarded.
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d    = bus.key_in;
        key_sync_d = sync1_q;
        key_db_d   = key_db_q;
        db_cnt_d   = '0;
        if (key_sync_q != key_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_db_d = ~key_db_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register plus all datapath flops
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            key_sync_q    <= 1'b0;
            key_db_q      <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= S_IDLE;
            press_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            code_q        <= '0;
            sym_count_q   <= '0;
            ascii_char_q  <= 8'h20;
            letter_done_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            key_sync_q    <= key_sync_d;
            key_db_q      <= key_db_d;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            press_cnt_q   <= press_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            code_q        <= code_d;
            sym_count_q   <= sym_count_d;
            ascii_char_q  <= ascii_char_d;
            letter_done_q <= letter_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (key_db_q) state_d = S_PRESS;
            S_PRESS: if (!key_db_q) state_d = S_GAP;
            // A new press takes priority over the gap expiring in the same cycle.
            S_GAP: begin
                if (key_db_q) begin
                    state_d = S_PRESS;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT:  if (hold_cnt_q == HOLD_END) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        press_cnt_d   = press_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        code_d        = code_q;
        sym_count_d   = sym_count_q;
        ascii_char_d  = ascii_char_q;
        letter_done_d = 1'b0;

        // The cycle that observes the release also counts toward the press.
        // The measured length therefore equals the debounced high time, and a
        // press of exactly DOT_MAX_CYC classifies as a dash.
        press_inc = (press_cnt_q == DOT_MAX) ? press_cnt_q : press_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (key_db_q) press_cnt_d = '0;
            end
            S_PRESS: begin
                if (key_db_q) begin
                    press_cnt_d = press_inc;
                end else begin
                    code_d      = {code_q[3:0], (press_inc >= DOT_MAX)};
                    sym_count_d = (sym_count_q == 3'd6) ? 3'd6 : sym_count_q + 3'd1;
                    gap_cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (key_db_q) begin
                    press_cnt_d = '0;
                end else if (gap_cnt_q == GAP_LAST) begin
                    hold_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            S_EMIT: begin
                // Step 0 loads the character. Steps 1..DONE_HOLD_CYC raise letter_done.
                // The final step clears the letter. ascii_char therefore leads
                // letter_done by one cycle.
                if (hold_cnt_q == '0) ascii_char_d = decode(sym_count_q, code_q);
                if (hold_cnt_q == HOLD_END) begin
                    hold_cnt_d  = '0;
                    code_d      = '0;
                    sym_count_d = '0;
                end else begin
                    hold_cnt_d    = hold_cnt_q + 1'b1;
                    letter_done_d = (hold_cnt_q != '0);
                end
            end
            default: begin
                press_cnt_d = '0;
            end
        endcase
    end

    assign bus.ascii_char  = ascii_char_q;
    assign bus.letter_done = letter_done_q;
    assign bus.sym_count   = sym_count_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule
